traffic_light_monitor: RTL

// Downstream safety stage for the UK traffic-light sequencer. Samples the

---
 rtl/traffic_light_monitor_if.sv | 40 ++++
 rtl/traffic_light_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor_if
// Description : Signal bundle between a traffic-light sequencer (master) and
//               the downstream safety monitor (slave).
//               master drives : red_in, amber_in, green_in, clear_fault
//               slave drives  : red_out, amber_out, green_out, fault,
//                               fault_code[2:0], aspect[1:0],
//                               dwell_cnt[CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  // Sequencer aspect request and software fault clear.
  logic             red_in;
  logic             amber_in;
  logic             green_in;
  logic             clear_fault;

  // Lamp drive and status from the monitor.
  logic             red_out;
  logic             amber_out;
  logic             green_out;
  logic             fault;
  logic [2:0]       fault_code;
  logic [1:0]       aspect;
  logic [CNT_W-1:0] dwell_cnt;

  modport master (
    output red_in, amber_in, green_in, clear_fault,
    input  red_out, amber_out, green_out, fault, fault_code, aspect, dwell_cnt
  );

  modport slave (
    input  red_in, amber_in, green_in, clear_fault,
    output red_out, amber_out, green_out, fault, fault_code, aspect, dwell_cnt
  );
endinterface
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Safety stage behind the UK traffic-light sequencer. Samples
//               red/amber/green every clock, checks for legal aspects, legal
//               order (R -> R+A -> G -> A -> R) and dwell limits, and drives
//               the physical lamps one cycle later. Any violation latches a
//               fault code and forces red-only lamps until clear_fault.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               bus (slave)  - red_in/amber_in/green_in/clear_fault in;
//                              red_out/amber_out/green_out, fault,
//                              fault_code, aspect, dwell_cnt out
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  wire                     clk,
  input  wire                     rst_n,
  traffic_light_monitor_if.slave  bus
);

  // Fault codes.
  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL = 3'd1;
  localparam logic [2:0] CODE_ORDER   = 3'd2;
  localparam logic [2:0] CODE_SHORT   = 3'd3;
  localparam logic [2:0] CODE_LONG    = 3'd4;

  // Aspect encodings.
  localparam logic [1:0] ASP_R  = 2'd0;
  localparam logic [1:0] ASP_RA = 2'd1;
  localparam logic [1:0] ASP_G  = 2'd2;
  localparam logic [1:0] ASP_A  = 2'd3;

  // Lamp pattern {r,a,g} for the safe (red-only) aspect.
  localparam logic [2:0] LAMPS_RED = 3'b100;

  localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       lamps;        // registered {red,amber,green} drive
  logic             fault;
  logic [2:0]       fault_code;
  logic [1:0]       aspect;
  logic [CNT_W-1:0] dwell_cnt;

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic [2:0] sample;
  logic       sample_legal;
  logic [1:0] sample_aspect;
  logic [1:0] successor;
  logic       aspect_changed;

  assign sample = {bus.red_in, bus.amber_in, bus.green_in};

  always_comb begin
    sample_legal  = 1'b1;
    sample_aspect = ASP_R;
    case (sample)
      3'b100:  sample_aspect = ASP_R;
      3'b110:  sample_aspect = ASP_RA;
      3'b001:  sample_aspect = ASP_G;
      3'b010:  sample_aspect = ASP_A;
      default: sample_legal  = 1'b0;
    endcase
  end

  // Two-bit add wraps A(3) back to R(0) naturally.
  assign successor      = aspect + 2'd1;
  assign aspect_changed = (sample_aspect != aspect);

  // --------------------------------------------------------------------------
  // Run-state checks, evaluated in priority order. Only meaningful when the
  // sample is legal; the illegal case is caught first.
  // --------------------------------------------------------------------------
  logic       run_fault;
  logic [2:0] run_code;

  always_comb begin
    run_fault = 1'b1;
    run_code  = CODE_NONE;
    if (!sample_legal) begin
      run_code = CODE_ILLEGAL;
    end else if (aspect_changed && (sample_aspect != successor)) begin
      run_code = CODE_ORDER;
    end else if (aspect_changed && (dwell_cnt < DWELL_MIN)) begin
      run_code = CODE_SHORT;
    end else if (!aspect_changed && (dwell_cnt == DWELL_MAX)) begin
      run_code = CODE_LONG;
    end else begin
      run_fault = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      lamps      <= LAMPS_RED;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
      aspect     <= ASP_R;
      dwell_cnt  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          // Illegal samples are simply waited out here; no fault is raised
          // until the sequencer has produced one legal aspect.
          lamps <= LAMPS_RED;
          if (sample_legal) begin
            state     <= ST_RUN;
            aspect    <= sample_aspect;
            dwell_cnt <= DWELL_ONE;
            lamps     <= sample;
          end
        end

        ST_RUN: begin
          if (run_fault) begin
            // aspect and dwell_cnt deliberately keep their pre-fault values
            // so software can see what the sequencer was doing.
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= run_code;
            lamps      <= LAMPS_RED;
          end else begin
            lamps <= sample;
            if (aspect_changed) begin
              aspect    <= sample_aspect;
              dwell_cnt <= DWELL_ONE;
            end else if (dwell_cnt != DWELL_SAT) begin
              dwell_cnt <= dwell_cnt + DWELL_ONE;
            end
          end
        end

        ST_FAULT: begin
          lamps <= LAMPS_RED;
          if (bus.clear_fault) begin
            state      <= ST_INIT;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            dwell_cnt  <= '0;
          end
        end

        default: begin
          // Unreachable encoding: fall back to the safe state.
          state <= ST_INIT;
          lamps <= LAMPS_RED;
        end
      endcase
    end
  end

  assign bus.red_out    = lamps[2];
  assign bus.amber_out  = lamps[1];
  assign bus.green_out  = lamps[0];
  assign bus.fault      = fault;
  assign bus.fault_code = fault_code;
  assign bus.aspect     = aspect;
  assign bus.dwell_cnt  = dwell_cnt;

endmodule
`default_nettype wire
